// File: rtl/i2c_slave.sv
// i2c_slave: write-only I2C receiver oversampled by clk; ACKs SLAVE_ADDR writes
// and strobes each completed data byte out on received_data/data_valid.
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] received_data,
  output logic       data_valid,
  output logic [2:0] state
);

  // state    | meaning
  // IDLE     | waiting for START
  // ADDR     | shifting in {addr[6:0], rw}
  // ADDR_ACK | pulling SDA low for the address ACK bit
  // DATA     | shifting in a data byte
  // DATA_ACK | pulling SDA low for the data ACK bit
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        valid_q, valid_d;
  logic        sda_low_q, sda_low_d;
  logic        scl_s1_q, scl_s2_q, scl_h_q;
  logic        sda_s1_q, sda_s2_q, sda_h_q;
  logic        drive_low;

  logic scl_rise, scl_fall, start_evt, stop_evt;

  // Synchronizers reset to the idle-bus level so release of reset makes no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_evt = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q & ~sda_low_q;
  assign stop_evt  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q & ~sda_low_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      rx_q      <= 8'h00;
      valid_q   <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      valid_q   <= valid_d;
      sda_low_q <= sda_low_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    valid_d   = 1'b0;
    sda_low_d = sda_low_q;
    if (start_evt) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      shift_d   = 8'h00;
      sda_low_d = 1'b0;
    end else if (stop_evt) begin
      state_d   = IDLE;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR, DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == DATA) begin
                rx_d    = shift_d;
                valid_d = 1'b1;
                state_d = DATA_ACK;
              end else if (shift_d[7:1] == SLAVE_ADDR && !shift_d[0]) begin
                state_d = ADDR_ACK;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        // First fall ends bit 8 and starts the ACK; second fall ends the ACK bit.
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = DATA;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state         = state_q;
    received_data = rx_q;
    data_valid    = valid_q;
    drive_low     = sda_low_q && (state_q == ADDR_ACK || state_q == DATA_ACK);
  end

  assign sda = drive_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master with directed and random write transactions,
// checked against a transaction-level model of which bytes must be ACKed and delivered.
`timescale 1ns/1ps
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m_low = 1'b0;
  wire        sda;
  logic [7:0] received_data;
  logic       data_valid;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int dv_len = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] model_rx = 8'h00;

  assign sda = sda_m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk),
    .reset(reset),
    .scl(scl),
    .sda(sda),
    .received_data(received_data),
    .data_valid(data_valid),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Collect every strobed byte and make sure each strobe lasts one clk.
  always @(negedge clk) begin
    if (data_valid) begin
      got_q.push_back(received_data);
      dv_len++;
    end else if (dv_len != 0) begin
      check_val("dv_width", dv_len, 1);
      dv_len = 0;
    end
  end

  task automatic bus_start();
    #50 sda_m_low = 1'b0;
    #50 scl = 1'b1;
    #50 sda_m_low = 1'b1;
    #50 scl = 1'b0;
  endtask

  task automatic bus_stop();
    #50 sda_m_low = 1'b1;
    #50 scl = 1'b1;
    #50 sda_m_low = 1'b0;
    #50;
  endtask

  task automatic bus_bit(input logic b);
    #50 sda_m_low = ~b;
    #50 scl = 1'b1;
    #100 scl = 1'b0;
  endtask

  task automatic bus_byte(input logic [7:0] b, output logic ack,
                          output logic [2:0] st_hi, output logic [2:0] st_after);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    #50 sda_m_low = 1'b0;
    #50 scl = 1'b1;
    #50 ack = (sda === 1'b0);
    st_hi = state;
    #50 scl = 1'b0;
    #40 st_after = state;
  endtask

  // One write transaction: address byte, bytes from tx_q, optional partial byte, optional STOP.
  task automatic xfer(input logic [7:0] ab, input int tail_bits, input logic do_stop);
    logic       acc, ack;
    logic [2:0] st_hi, st_after;
    logic [7:0] d;
    acc = (ab[7:1] == 7'h50) && (ab[0] == 1'b0);
    bus_start();
    bus_byte(ab, ack, st_hi, st_after);
    check_val("addr_ack", ack, acc);
    check_val("addr_st_hi", st_hi, acc ? 3'd2 : 3'd0);
    check_val("addr_st_after", st_after, acc ? 3'd3 : 3'd0);
    while (tx_q.size() > 0) begin
      d = tx_q.pop_front();
      bus_byte(d, ack, st_hi, st_after);
      check_val("data_ack", ack, acc);
      check_val("data_st_hi", st_hi, acc ? 3'd4 : 3'd0);
      check_val("data_st_after", st_after, acc ? 3'd3 : 3'd0);
      if (acc) begin
        exp_q.push_back(d);
        model_rx = d;
      end
    end
    for (int i = 0; i < tail_bits; i++) bus_bit(1'($urandom_range(0, 1)));
    if (do_stop) begin
      bus_stop();
      check_val("stop_idle", state, 3'd0);
    end
    #100;
    check_val("n_bytes", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_val("byte", got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check_val("rx_hold", received_data, model_rx);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #20;
    check_val("rst_state", state, 3'd0);
    sda_m_low = 1'b0;
    #20;
    check_val("rst_sda", sda, 1'b1);
    scl = 1'b1;
    #50 reset = 1'b0;
    model_rx = 8'h00;
    got_q.delete();
    exp_q.delete();
    #50;
    check_val("rst_rx", received_data, 8'h00);
  endtask

  initial begin
    #50 reset = 1'b0;
    #10;
    check_val("init_state", state, 3'd0);
    check_val("init_rx", received_data, 8'h00);
    check_val("init_dv", data_valid, 1'b0);
    check_val("init_sda", sda, 1'b1);

    tx_q = '{8'h3C};
    xfer(8'hA0, 0, 1'b0);
    #1000;
    check_val("rx_after_1us", received_data, 8'h3C);
    bus_stop();

    tx_q = '{8'h3C, 8'h77};
    xfer(8'hA2, 0, 1'b1);

    xfer(8'hA1, 0, 1'b0);
    tx_q = '{8'h55, 8'hAA};
    xfer(8'hA0, 0, 1'b1);
    check_val("rx_final_aa", received_data, 8'hAA);

    tx_q = '{8'h12};
    xfer(8'hA0, 4, 1'b1);
    check_val("rx_after_midstop", received_data, 8'h12);

    // Reset mid data byte.
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(i == 0 ? 1'b0 : (i == 7 || i == 5));
    #50 sda_m_low = 1'b0;
    #50 scl = 1'b1;
    #100 scl = 1'b0;
    for (int i = 0; i < 3; i++) bus_bit(1'b0);
    do_reset();

    // Reset while the slave is pulling SDA low for the address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(i == 7 || i == 5);
    #50 sda_m_low = 1'b0;
    #50 scl = 1'b1;
    #50 check_val("ack_driven", sda, 1'b0);
    do_reset();

    for (int t = 0; t < 25; t++) begin
      logic [7:0] ab;
      int nd, kind;
      case ($urandom_range(0, 3))
        0, 1: ab = 8'hA0;
        2: ab = 8'hA1;
        default: ab = 8'($urandom);
      endcase
      nd = $urandom_range(0, 3);
      for (int i = 0; i < nd; i++) tx_q.push_back(8'($urandom));
      kind = $urandom_range(0, 2);
      case (kind)
        0: xfer(ab, 0, 1'b1);
        1: xfer(ab, $urandom_range(1, 7), 1'b1);
        default: xfer(ab, 0, 1'b0);
      endcase
    end
    bus_stop();
    check_val("final_idle", state, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
